refresh_scheduler: RTL and testbench

Multi-rank DRAM refresh scheduler for the memory controller. It keeps a per-rank refresh-interval timer and counts how many refreshes each rank owes, up to a parametrised postponement limit. Each rank gets a request/acknowledge handshake, an urgency flag and a sticky overflow flag. Rank timers are staggered so ranks do not come due in the same cycle. It sits between the clock/reset tree and the command arbiter, which decides when to issue the refresh commands.

---
 rtl/refresh_pkg.sv | 16 +
 rtl/refresh_rank_ctr.sv | 64 ++++++
 rtl/refresh_scheduler.sv | 38 +++
 tb/tb_refresh_scheduler.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/refresh_pkg.sv
// Shared defaults and helpers for the multi-rank DRAM refresh scheduler.
package refresh_pkg;

    // 7.8 us refresh interval at 100 MHz, JEDEC-style postponement depth.
    localparam int unsigned TREFI_DEFAULT        = 780;
    localparam int unsigned MAX_POSTPONE_DEFAULT = 8;

    function automatic int unsigned stagger_offset(
        input int unsigned rank,
        input int unsigned trefi,
        input int unsigned num_ranks
    );
        return rank * (trefi / num_ranks);
    endfunction

endpackage

// File: rtl/refresh_rank_ctr.sv
// One rank's refresh-interval timer, owed-refresh count and status flags.
module refresh_rank_ctr
    import refresh_pkg::*;
#(
    parameter int unsigned TREFI_CYCLES = TREFI_DEFAULT,
    parameter int unsigned MAX_POSTPONE = MAX_POSTPONE_DEFAULT,
    parameter int unsigned OFFSET       = 0,
    parameter int unsigned CNT_W        = $clog2(TREFI_CYCLES),
    parameter int unsigned OWE_W        = $clog2(MAX_POSTPONE + 2)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             refreshed,
    output logic             refresh,
    output logic             refresh_urgent,
    output logic             refresh_overflow,
    output logic [OWE_W-1:0] owed
);

    localparam logic [CNT_W-1:0] CTR_LAST   = CNT_W'(TREFI_CYCLES - 1);
    localparam logic [CNT_W-1:0] CTR_INIT   = CNT_W'(OFFSET);
    localparam logic [OWE_W-1:0] OWED_SAT   = OWE_W'(MAX_POSTPONE + 1);
    localparam logic [OWE_W-1:0] OWED_URG   = OWE_W'(MAX_POSTPONE);

    logic [CNT_W-1:0] ctr;
    logic [OWE_W-1:0] owed_nxt;
    logic             overflow_nxt;
    logic             tick;
    logic             ack;

    assign tick = (ctr == CTR_LAST);
    // An ack against nothing owed is dropped silently.
    assign ack  = refreshed && (owed != '0);

    always_comb begin
        owed_nxt     = owed;
        overflow_nxt = refresh_overflow;
        if (tick && !ack) begin
            if (owed == OWED_SAT) begin
                overflow_nxt = 1'b1;
            end else begin
                owed_nxt = owed + OWE_W'(1);
            end
        end else if (ack && !tick) begin
            owed_nxt = owed - OWE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctr              <= CTR_INIT;
            owed             <= '0;
            refresh_overflow <= 1'b0;
        end else begin
            ctr              <= tick ? '0 : ctr + CNT_W'(1);
            owed             <= owed_nxt;
            refresh_overflow <= overflow_nxt;
        end
    end

    assign refresh        = (owed != '0);
    assign refresh_urgent = (owed >= OWED_URG);

endmodule

// File: rtl/refresh_scheduler.sv
// Multi-rank refresh scheduler: staggered per-rank timers packed onto flat vectors.
module refresh_scheduler
    import refresh_pkg::*;
#(
    parameter int unsigned NUM_RANKS    = 2,
    parameter int unsigned TREFI_CYCLES = TREFI_DEFAULT,
    parameter int unsigned MAX_POSTPONE = MAX_POSTPONE_DEFAULT,
    parameter int unsigned CNT_W        = $clog2(TREFI_CYCLES),
    parameter int unsigned OWE_W        = $clog2(MAX_POSTPONE + 2)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_RANKS-1:0]       refreshed,
    output logic [NUM_RANKS-1:0]       refresh,
    output logic [NUM_RANKS-1:0]       refresh_urgent,
    output logic [NUM_RANKS-1:0]       refresh_overflow,
    output logic [NUM_RANKS*OWE_W-1:0] owed_count
);

    for (genvar r = 0; r < NUM_RANKS; r++) begin : g_rank
        refresh_rank_ctr #(
            .TREFI_CYCLES (TREFI_CYCLES),
            .MAX_POSTPONE (MAX_POSTPONE),
            .OFFSET       (stagger_offset(r, TREFI_CYCLES, NUM_RANKS)),
            .CNT_W        (CNT_W),
            .OWE_W        (OWE_W)
        ) u_rank (
            .clk              (clk),
            .rst_n            (reset),
            .refreshed        (refreshed[r]),
            .refresh          (refresh[r]),
            .refresh_urgent   (refresh_urgent[r]),
            .refresh_overflow (refresh_overflow[r]),
            .owed             (owed_count[r*OWE_W +: OWE_W])
        );
    end

endmodule

// File: tb/tb_refresh_scheduler.sv
// Self-checking bench: directed timing checks plus randomized acks/resets against a behavioural model.
module tb_refresh_scheduler;

    localparam int NR   = 2;
    localparam int T    = 16;
    localparam int MP   = 3;
    localparam int OW   = $clog2(MP + 2);

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic [NR-1:0]      refreshed = '0;
    logic [NR-1:0]      refresh;
    logic [NR-1:0]      refresh_urgent;
    logic [NR-1:0]      refresh_overflow;
    logic [NR*OW-1:0]   owed_count;

    int tests = 0;
    int fails = 0;
    int cur   = 0;

    // Model state: edges since reset release (mod T), owed and overflow per rank.
    int m_n;
    int m_owed [NR];
    bit m_ovf  [NR];

    refresh_scheduler #(
        .NUM_RANKS    (NR),
        .TREFI_CYCLES (T),
        .MAX_POSTPONE (MP)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .refreshed        (refreshed),
        .refresh          (refresh),
        .refresh_urgent   (refresh_urgent),
        .refresh_overflow (refresh_overflow),
        .owed_count       (owed_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit is_tick(input int r, input int n);
        return ((r * (T / NR) + n) % T) == T - 1;
    endfunction

    function automatic int next_owed(input int o, input bit tk, input bit ak);
        int d;
        d = (tk ? 1 : 0) - ((ak && o > 0) ? 1 : 0);
        if (o + d > MP + 1) return MP + 1;
        return o + d;
    endfunction

    function automatic bit next_ovf(input bit v, input int o, input bit tk, input bit ak);
        return v || (tk && !ak && o == MP + 1);
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_n <= 0;
            for (int r = 0; r < NR; r++) begin
                m_owed[r] <= 0;
                m_ovf[r]  <= 1'b0;
            end
        end else begin
            m_n <= (m_n + 1) % T;
            for (int r = 0; r < NR; r++) begin
                m_owed[r] <= next_owed(m_owed[r], is_tick(r, m_n), refreshed[r]);
                m_ovf[r]  <= next_ovf(m_ovf[r], m_owed[r], is_tick(r, m_n), refreshed[r]);
            end
        end
    end

    always @(negedge clk) begin
        for (int r = 0; r < NR; r++) begin
            check("model_refresh",  int'(refresh[r]),          int'(m_owed[r] > 0));
            check("model_urgent",   int'(refresh_urgent[r]),   int'(m_owed[r] >= MP));
            check("model_overflow", int'(refresh_overflow[r]), int'(m_ovf[r]));
            check("model_owed",     int'(owed_count[r*OW +: OW]), m_owed[r]);
        end
    end

    task automatic goto(input int k);
        while (cur < k) begin
            @(negedge clk);
            cur++;
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        #1 reset = 1'b1;
        cur = 0;
    endtask

    task automatic first_request_checks();
        goto(7);
        check("r1_before_edge8", int'(refresh[1]), 0);
        goto(8);
        check("r1_after_edge8", int'(refresh[1]), 1);
        check("r0_after_edge8", int'(refresh[0]), 0);
        goto(15);
        check("r0_before_edge16", int'(refresh[0]), 0);
        goto(16);
        check("r0_after_edge16", int'(refresh[0]), 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_refresh",  int'(refresh), 0);
        check("reset_urgent",   int'(refresh_urgent), 0);
        check("reset_overflow", int'(refresh_overflow), 0);
        check("reset_owed",     int'(owed_count), 0);

        release_reset();
        first_request_checks();
        refreshed = 2'b01;
        goto(17);
        refreshed = 2'b01;
        check("ack_drop_r0", int'(refresh[0]), 0);
        goto(18);
        refreshed = 2'b00;
        check("ack_owed0_noop", int'(owed_count), 8);
        check("ack_owed0_noovf", int'(refresh_overflow), 0);
        goto(24);
        check("r1_owed2_edge24", int'(owed_count[OW +: OW]), 2);
        goto(31);
        check("r0_fixed_interval_pre", int'(refresh[0]), 0);
        goto(32);
        check("r0_fixed_interval", int'(refresh[0]), 1);
        goto(40);
        check("r1_owed3_edge40", int'(owed_count[OW +: OW]), 3);
        check("r1_urgent_edge40", int'(refresh_urgent[1]), 1);
        goto(47);
        refreshed = 2'b01;
        goto(48);
        refreshed = 2'b00;
        check("tick_ack_owed0", int'(owed_count[OW-1:0]), 1);
        check("tick_ack_refresh0", int'(refresh[0]), 1);
        goto(56);
        check("r1_sat_edge56", int'(owed_count[OW +: OW]), 4);
        goto(71);
        check("r1_no_ovf_edge71", int'(refresh_overflow[1]), 0);
        goto(72);
        check("r1_ovf_edge72", int'(refresh_overflow[1]), 1);
        check("r1_hold4_edge72", int'(owed_count[OW +: OW]), 4);
        goto(80);
        check("r0_owed3_edge80", int'(owed_count[OW-1:0]), 3);

        #2 reset = 1'b0;
        #1;
        check("midrun_reset_refresh",  int'(refresh), 0);
        check("midrun_reset_urgent",   int'(refresh_urgent), 0);
        check("midrun_reset_overflow", int'(refresh_overflow), 0);
        check("midrun_reset_owed",     int'(owed_count), 0);
        release_reset();
        first_request_checks();
        goto(24);
        check("rerun_r1_owed2", int'(owed_count[OW +: OW]), 2);

        // Random acks with occasional asynchronous reset pulses.
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            refreshed = NR'($urandom_range(0, 3) == 0 ? $urandom : 0);
            if ($urandom_range(0, 199) == 0) begin
                #2 reset = 1'b0;
                @(negedge clk);
                #1 reset = 1'b1;
            end
        end
        refreshed = '0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
